msu_sequencer: RTL and testbench
================================

MSU_SEQUENCER -- requirements
Module: msu_sequencer

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 66: number of polynomial coefficients, 64 nonredundant plus 2 redundant.
REQ-002 SHALL have parameter BIT_LEN, default 17: width of each coefficient.
REQ-003 SHALL have parameter ITER_W, default 64: width of the iteration count.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum number of cycles spent waiting for one squaring.
REQ-005 clk  in  1  the only clock; all logic is rising-edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse requesting a new job.
REQ-008 t_final  in  ITER_W  number of squarings to perform; sampled on start.
REQ-009 sq_in  in  NUM_ELEMENTS*BIT_LEN  initial value, coefficient j at bits [j*BIT_LEN +: BIT_LEN]; sampled on start.
REQ-010 abort  in  1  level; cancels the current job.
REQ-011 msq_start  out  1  one-cycle start pulse to the squarer.
REQ-012 msq_sq_in  out  NUM_ELEMENTS*BIT_LEN  operand to the squarer.
REQ-013 msq_valid  in  1  one-cycle squarer result pulse.
REQ-014 msq_sq_out  in  NUM_ELEMENTS*BIT_LEN  squarer result.
REQ-015 busy  out  1  high while the state is not IDLE.
REQ-016 done  out  1  one-cycle job-complete pulse.
REQ-017 error  out  1  one-cycle pulse on timeout or abort.
REQ-018 sq_out  out  NUM_ELEMENTS*BIT_LEN  final result; held until the next accepted start.
REQ-019 iter  out  ITER_W  number of completed squarings in the current or last job.

Function
REQ-020 The block SHALL implement states IDLE, LAUNCH, WAIT and FINISH with one-hot or binary encoding.
REQ-021 In IDLE, start with t_final!=0 SHALL latch t_final and sq_in into the current-value register, clear iter, and go to LAUNCH.
REQ-022 In IDLE, start with t_final==0 SHALL set sq_out=sq_in and iter=0, and go to FINISH with no squarer activity.
REQ-023 LAUNCH SHALL assert msq_start for exactly 1 cycle, with msq_sq_in equal to the current value, then go to WAIT.
REQ-024 msq_sq_in SHALL stay driven from the current-value register and stay stable through WAIT.
REQ-025 In WAIT, msq_valid SHALL load the current value from msq_sq_out and increment iter (wrapping modulo 2^ITER_W).
REQ-026 On that msq_valid, the block SHALL go to FINISH if the new iter equals the latched t_final, else to LAUNCH.
REQ-027 Back-to-back throughput SHALL be: msq_start occurs exactly 2 cycles after the msq_valid that produced its operand.
REQ-028 FINISH SHALL copy the current value to sq_out (except in the REQ-022 path), assert done for 1 cycle, and return to IDLE.
REQ-029 sq_out SHALL be valid in the same cycle as done.
REQ-030 start while busy SHALL be ignored and SHALL NOT disturb the running job.
REQ-031 msq_valid outside WAIT SHALL be ignored.
REQ-032 abort high in any non-IDLE state SHALL force IDLE on the next edge, pulse error, and leave sq_out and done unchanged; iter keeps its count.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 abort takes priority over a simultaneous msq_valid.
REQ-035 A watchdog SHALL count cycles in WAIT and clear on each LAUNCH.
REQ-036 Reaching TIMEOUT cycles without msq_valid SHALL pulse error and go to IDLE.
REQ-037 A start in the cycle where the state returns to IDLE SHALL be accepted on the following cycle only; IDLE must be the registered state when start is sampled.

Reset
REQ-038 reset low SHALL asynchronously force state IDLE and clear msq_start, busy, done, error, iter, sq_out, msq_sq_in, the watchdog and the latched t_final.
REQ-039 Deassertion is assumed synchronized upstream; the first start is accepted on the first edge after deassertion.
REQ-040 reset asserted mid-job SHALL discard the job; no done is produced.

Verification
REQ-041 The bench SHALL cover: t_final=3, squarer model returning x+1 per coefficient after 8 cycles -> exactly 3 msq_start, done once, iter=3, sq_out=sq_in+3 in every coefficient.
REQ-042 The bench SHALL cover: t_final=0 -> done 2 cycles after start, sq_out=sq_in, no msq_start.
REQ-043 The bench SHALL cover: abort in the 4th WAIT cycle of iteration 2 with t_final=10 -> error pulse, busy low next cycle, no done, a later start runs normally.
REQ-044 The bench SHALL cover: squarer never responds, TIMEOUT=16 -> error exactly 16 cycles after msq_start, then IDLE.
REQ-045 The bench SHALL cover: start pulsed during WAIT and msq_valid injected during IDLE -> no state, iter or sq_out change.
REQ-046 The bench SHALL cover: reset low mid-WAIT -> all outputs 0 immediately (asynchronously), no done after release.

Source files
------------

// File: rtl/msu_sequencer.sv
// Iteration controller for the modular squaring unit: feeds the squarer
// t_final times back-to-back, with abort and a per-squaring watchdog.
module msu_sequencer #(
    parameter int unsigned NUM_ELEMENTS = 66,
    parameter int unsigned BIT_LEN      = 17,
    parameter int unsigned ITER_W       = 64,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ITER_W-1:0]               t_final,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_in,
    input  logic                            abort,
    output logic                            msq_start,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0] msq_sq_in,
    input  logic                            msq_valid,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0] msq_sq_out,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_out,
    output logic [ITER_W-1:0]               iter
);

    localparam int unsigned W    = NUM_ELEMENTS * BIT_LEN;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      cur_q, cur_d;
    logic [W-1:0]      sq_out_q, sq_out_d;
    logic [ITER_W-1:0] tfinal_q, tfinal_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] iter_inc;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              msq_start_q, msq_start_d;

    assign iter_inc = iter_q + ITER_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            sq_out_q    <= '0;
            tfinal_q    <= '0;
            iter_q      <= '0;
            wd_q        <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            msq_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            sq_out_q    <= sq_out_d;
            tfinal_q    <= tfinal_d;
            iter_q      <= iter_d;
            wd_q        <= wd_d;
            done_q      <= done_d;
            error_q     <= error_d;
            msq_start_q <= msq_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        sq_out_d    = sq_out_q;
        tfinal_d    = tfinal_q;
        iter_d      = iter_q;
        wd_d        = wd_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        msq_start_d = 1'b0;

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tfinal_d = t_final;
                        cur_d    = sq_in;
                        iter_d   = '0;
                        if (t_final != '0) begin
                            state_d = S_LAUNCH;
                        end else begin
                            // Zero-length job: cur also holds sq_in, so the FINISH copy is a no-op
                            sq_out_d = sq_in;
                            state_d  = S_FINISH;
                        end
                    end
                end
                S_LAUNCH: begin
                    msq_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    if (msq_valid) begin
                        cur_d   = msq_sq_out;
                        iter_d  = iter_inc;
                        state_d = (iter_inc == tfinal_q) ? S_FINISH : S_LAUNCH;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                S_FINISH: begin
                    sq_out_d = cur_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign msq_start = msq_start_q;
    assign msq_sq_in = cur_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign sq_out    = sq_out_q;
    assign iter      = iter_q;

endmodule

// File: tb/tb_msu_sequencer.sv
// Directed bench for msu_sequencer with a behavioural squarer that returns
// each coefficient incremented by one, eight cycles after msq_start.
module tb_msu_sequencer;

    localparam int unsigned NE = 8;
    localparam int unsigned BL = 17;
    localparam int unsigned IW = 64;
    localparam int unsigned TO = 16;
    localparam int unsigned W  = NE * BL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] t_final;
    logic [W-1:0]  sq_in;
    logic          abort;
    logic          msq_start;
    logic [W-1:0]  msq_sq_in;
    logic          msq_valid;
    logic [W-1:0]  msq_sq_out;
    logic          busy, done, error;
    logic [W-1:0]  sq_out;
    logic [IW-1:0] iter;

    logic          model_valid = 1'b0;
    logic [W-1:0]  model_data  = '0;
    logic          inj_valid   = 1'b0;
    logic [W-1:0]  inj_data    = '0;
    logic          sq_en       = 1'b1;

    assign msq_valid  = model_valid | inj_valid;
    assign msq_sq_out = inj_valid ? inj_data : model_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0, n_done = 0, ncyc = 0, lastv = 0, gap = -1;

    always #5 clk = ~clk;

    msu_sequencer #(
        .NUM_ELEMENTS(NE),
        .BIT_LEN     (BL),
        .ITER_W      (IW),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .t_final   (t_final),
        .sq_in     (sq_in),
        .abort     (abort),
        .msq_start (msq_start),
        .msq_sq_in (msq_sq_in),
        .msq_valid (msq_valid),
        .msq_sq_out(msq_sq_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .sq_out    (sq_out),
        .iter      (iter)
    );

    function automatic logic [W-1:0] mkvec(input int unsigned base);
        logic [W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < NE; j++) v[j*BL +: BL] = BL'(base + j * 7);
        return v;
    endfunction

    function automatic logic [W-1:0] addvec(input logic [W-1:0] v, input int unsigned k);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < NE; j++) r[j*BL +: BL] = v[j*BL +: BL] + BL'(k);
        return r;
    endfunction

    // Squarer stand-in
    initial begin
        logic [W-1:0] cap;
        forever begin
            @(posedge clk); #1;
            if (msq_start && sq_en) begin
                cap = msq_sq_in;
                repeat (7) @(posedge clk);
                #1;
                model_data  = addvec(cap, 1);
                model_valid = 1'b1;
                @(posedge clk); #1;
                model_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (msq_valid) lastv = ncyc;
        if (msq_start) begin
            n_start++;
            if (lastv != 0) gap = ncyc - lastv;
        end
        if (done) n_done++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_mstart(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (msq_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic go(input logic [IW-1:0] tf, input logic [W-1:0] v);
        t_final = tf;
        sq_in   = v;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    initial begin
        bit ok;
        int s0, d0, k;
        logic [W-1:0] va, vb, vc, vd;
        logic [W-1:0] snap_q, snap_in;
        logic [IW-1:0] snap_it;

        va = mkvec(100);
        vb = mkvec(5000);
        vc = mkvec(77);
        vd = mkvec(131000);
        reset = 1'b0; start = 1'b0; t_final = '0; sq_in = '0; abort = 1'b0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_iter", iter, 0);
        chk("rst_sq_out", sq_out, 0);
        chk("rst_msq_sq_in", msq_sq_in, 0);
        chk("rst_msq_start", msq_start, 0);
        reset = 1'b1;

        // Three squarings
        s0 = n_start; d0 = n_done;
        go(3, va);
        chk("t3_busy", busy, 1);
        wait_done(ok);
        chk("t3_done_seen", ok, 1);
        chk("t3_iter", iter, 3);
        chk("t3_sq_out", sq_out, addvec(va, 3));
        chk("t3_starts", n_start - s0, 3);
        chk("t3_gap", gap, 2);
        cyc(3);
        chk("t3_done_once", n_done - d0, 1);
        chk("t3_idle", busy, 0);

        // Zero-length job
        s0 = n_start;
        go(0, vb);
        chk("t0_done_early", done, 0);
        cyc(1);
        chk("t0_done", done, 1);
        chk("t0_sq_out", sq_out, vb);
        chk("t0_iter", iter, 0);
        chk("t0_starts", n_start - s0, 0);

        // Abort in the 4th WAIT cycle of iteration 2
        cyc(2);
        d0 = n_done;
        go(10, va);
        wait_mstart(ok);
        chk("ab_m1", ok, 1);
        wait_mstart(ok);
        chk("ab_m2", ok, 1);
        cyc(3);
        chk("ab_busy_before", busy, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_error", error, 1);
        chk("ab_iter", iter, 1);
        chk("ab_sq_out", sq_out, vb);
        cyc(1);
        chk("ab_error_pulse", error, 0);
        cyc(12);
        chk("ab_stays_idle", busy, 0);
        chk("ab_iter_kept", iter, 1);
        chk("ab_no_done", n_done - d0, 0);
        go(2, vc);
        wait_done(ok);
        chk("ab_rerun_done", ok, 1);
        chk("ab_rerun_iter", iter, 2);
        chk("ab_rerun_sq_out", sq_out, addvec(vc, 2));

        // Squarer silent: watchdog
        cyc(2);
        sq_en = 1'b0;
        go(5, va);
        wait_mstart(ok);
        chk("to_mstart", ok, 1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (error) begin
                k = i;
                break;
            end
        end
        chk("to_latency", k, TO);
        chk("to_idle", busy, 0);
        cyc(1);
        chk("to_error_pulse", error, 0);
        sq_en = 1'b1;

        // Stray start during WAIT and stray msq_valid during IDLE
        go(2, vd);
        wait_mstart(ok);
        chk("st_mstart", ok, 1);
        cyc(2);
        snap_q = sq_out; snap_in = msq_sq_in; snap_it = iter;
        go(7, va);
        chk("st_busy", busy, 1);
        chk("st_iter", iter, snap_it);
        chk("st_sq_out", sq_out, snap_q);
        chk("st_msq_sq_in", msq_sq_in, snap_in);
        wait_done(ok);
        chk("st_done", ok, 1);
        chk("st_final_iter", iter, 2);
        chk("st_final_sq_out", sq_out, addvec(vd, 2));
        cyc(2);
        s0 = n_start;
        inj_data  = va;
        inj_valid = 1'b1;
        cyc(1);
        inj_valid = 1'b0;
        cyc(1);
        chk("iv_busy", busy, 0);
        chk("iv_iter", iter, 2);
        chk("iv_sq_out", sq_out, addvec(vd, 2));
        chk("iv_no_start", n_start - s0, 0);

        // Reset mid-WAIT
        d0 = n_done;
        go(3, va);
        wait_mstart(ok);
        chk("rs_mstart", ok, 1);
        cyc(2);
        reset = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_iter", iter, 0);
        chk("rs_sq_out", sq_out, 0);
        chk("rs_msq_sq_in", msq_sq_in, 0);
        chk("rs_msq_start", msq_start, 0);
        chk("rs_done", done, 0);
        chk("rs_error", error, 0);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(6);
        chk("rs_no_done", n_done - d0, 0);
        chk("rs_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
